// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
// press_classifier: groups debounced press pulses into single/double/triple
// gestures and presents them on a one-deep valid/ready event register.
// Optional feature macro: BTN_TRIPLE_EN (adds the TWO state and triple code).
// Revision: 1.0
// ============================================================================
module press_classifier #(
  parameter int WINDOW_CYC = 30_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_pulse,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop,
  output logic       busy
);

  localparam int             CW       = $clog2(WINDOW_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WINDOW_CYC - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ONE  = 2'd1;
`ifdef BTN_TRIPLE_EN
  localparam logic [1:0] ST_TWO  = 2'd2;
  localparam logic [1:0] CODE_TRIPLE = 2'b11;
`endif

  localparam logic [1:0] CODE_SINGLE = 2'b01;
  localparam logic [1:0] CODE_DOUBLE = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cls_valid_q, cls_valid_d;
  logic [1:0]    cls_code_q, cls_code_d;
  logic          evt_valid_q, evt_valid_d;
  logic [1:0]    evt_code_q, evt_code_d;
  logic          evt_drop_q, evt_drop_d;

  // Gesture collection FSM; a classification is staged for one cycle before
  // it reaches the event register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cls_valid_d = 1'b0;
    cls_code_d  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (pb_pulse) begin
          state_d = ST_ONE;
          cnt_d   = '0;
        end
      end
      ST_ONE: begin
        if (pb_pulse) begin
`ifdef BTN_TRIPLE_EN
          state_d = ST_TWO;
          cnt_d   = '0;
`else
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cls_valid_d = 1'b1;
          cls_code_d  = CODE_DOUBLE;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cls_valid_d = 1'b1;
          cls_code_d  = CODE_SINGLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef BTN_TRIPLE_EN
      ST_TWO: begin
        if (pb_pulse) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cls_valid_d = 1'b1;
          cls_code_d  = CODE_TRIPLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cls_valid_d = 1'b1;
          cls_code_d  = CODE_DOUBLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Event register: a same-edge accept frees the slot for the new event.
  always_comb begin
    evt_valid_d = evt_valid_q & ~evt_ready;
    evt_code_d  = evt_code_q;
    evt_drop_d  = 1'b0;
    if (cls_valid_q) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = cls_code_q;
      end else begin
        evt_valid_d = 1'b1;
        evt_drop_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cls_valid_q <= 1'b0;
      cls_code_q  <= 2'b00;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      evt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cls_valid_q <= cls_valid_d;
      cls_code_q  <= cls_code_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_drop  = evt_drop_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// tb_press_classifier: directed + random presses against a timestamp-based
// gesture model; events are scoreboarded through a queue. Honours BTN_TRIPLE_EN.
module tb_press_classifier;

  localparam int W = 8;
`ifdef BTN_TRIPLE_EN
  localparam int MAXP = 3;
`else
  localparam int MAXP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_pulse = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_drop;
  logic       busy;

  press_classifier #(.WINDOW_CYC(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_pulse  (pb_pulse),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .evt_drop  (evt_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int npress = 0;
  int last_press = 0;
  bit pend = 0;
  int pend_code = 0;
  bit m_occ = 0;
  bit m_drop = 0;
  bit m_busy = 0;
  int exp_code_q[$];
  int exp_edge_q[$];
  bit prev_valid = 0;
  bit prev_hs = 0;
  int cur_code = 0;

  task automatic model_clear();
    npress = 0; pend = 0; m_occ = 0; m_drop = 0; m_busy = 0;
    exp_code_q.delete(); exp_edge_q.delete();
    prev_valid = 0; prev_hs = 0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      // A gesture classified on the previous edge reaches the output now.
      m_drop = 0;
      if (pend) begin
        if (!m_occ || evt_ready) begin
          m_occ = 1;
          exp_code_q.push_back(pend_code);
          exp_edge_q.push_back(cyc);
        end else begin
          m_drop = 1;
        end
      end else if (m_occ && evt_ready) begin
        m_occ = 0;
      end
      pend = 0;
      // Presses no more than W edges apart belong to the same gesture.
      if (npress > 0) begin
        if (pb_pulse) begin
          npress++;
          last_press = cyc;
          if (npress == MAXP) begin
            pend = 1; pend_code = npress; npress = 0;
          end
        end else if (cyc - last_press == W) begin
          pend = 1; pend_code = npress; npress = 0;
        end
      end else if (pb_pulse) begin
        npress = 1;
        last_press = cyc;
      end
      m_busy = (npress > 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("evt_drop", int'(evt_drop), int'(m_drop));
      chk("evt_valid", int'(evt_valid), int'(m_occ));
      if (evt_valid && (!prev_valid || prev_hs)) begin
        if (exp_code_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          cur_code = exp_code_q.pop_front();
          chk("evt_code", int'(evt_code), cur_code);
          chk("evt_edge", cyc, exp_edge_q.pop_front());
        end
      end else if (evt_valid) begin
        chk("evt_code_hold", int'(evt_code), cur_code);
      end
      prev_valid = evt_valid;
      prev_hs    = evt_valid && evt_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_drive(input bit p, input bit r);
    pb_pulse  = p;
    evt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, r);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_code", int'(evt_code), 0);
    chk("rst_evt_drop", int'(evt_drop), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(2, 1'b1);

    // single press with consumer ready
    cyc_drive(1'b1, 1'b1); idle(14, 1'b1);
    // two presses 5 apart
    cyc_drive(1'b1, 1'b1); idle(4, 1'b1); cyc_drive(1'b1, 1'b1); idle(14, 1'b1);
    // presses at t, t+3, t+6
    cyc_drive(1'b1, 1'b1); idle(2, 1'b1); cyc_drive(1'b1, 1'b1);
    idle(2, 1'b1); cyc_drive(1'b1, 1'b1); idle(14, 1'b1);
    // second press exactly on the expiry edge
    cyc_drive(1'b1, 1'b1); idle(7, 1'b1); cyc_drive(1'b1, 1'b1); idle(14, 1'b1);
    // two singles with consumer stalled: second one is dropped
    cyc_drive(1'b1, 1'b0); idle(12, 1'b0);
    cyc_drive(1'b1, 1'b0); idle(12, 1'b0);
    idle(3, 1'b1);
    // reset in ONE with an event pending
    cyc_drive(1'b1, 1'b0); idle(12, 1'b0);
    cyc_drive(1'b1, 1'b0); idle(2, 1'b0);
    rst = 1'b1;
    model_clear();
    #1;
    chk("midrst_evt_valid", int'(evt_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20, 1'b1);

    // randomized presses and back-pressure
    for (int g = 0; g < 400; g++) begin
      cyc_drive(1'b1, ($urandom_range(0, 9) < 6));
      for (int k = $urandom_range(0, 11); k > 0; k--)
        cyc_drive(1'b0, ($urandom_range(0, 9) < 6));
    end

    idle(30, 1'b1);
    chk("leftover_events", exp_code_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
